// File: rtl/linebuf_ctrl.sv
// Line buffer sequencer: frame/line position tracking, line_end restart pulse and
// IDLE->FILL->RUN window-valid sequencing. Optional stats via LINEBUF_CTRL_STATS_EN.
module linebuf_ctrl #(
    parameter int SCREENWIDTH = 1600,
    parameter int LINE_END    = 2048,
    parameter int MAX_LINES   = 1024,
    parameter int BUF_DEPTH   = 3,
    parameter int CW          = $clog2(LINE_END),
    parameter int RW          = $clog2(MAX_LINES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dv_i,
    input  logic          vs_i,
    output logic          line_end_o,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          win_valid_o,
    output logic          run_o,
    output logic          ovf_o,
    output logic [CW-1:0] width_o,
    output logic [RW-1:0] height_o
);

    localparam logic [CW-1:0] COL_MAX   = CW'(SCREENWIDTH - 1);
    localparam logic [CW-1:0] WIN_COL   = CW'(BUF_DEPTH - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(MAX_LINES - 1);
    localparam logic [RW-1:0] FILL_LAST = RW'(BUF_DEPTH - 2);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

    state_t        r_state;
    logic          r_dv_q;
    logic          r_vs_q;
    logic          r_inline;   // at least one beat counted in the current line
    logic          w_fs;
    logic          w_le;
    logic          w_ovf_beat;
    logic [CW-1:0] w_pcol;

    assign w_fs       = ~r_vs_q & vs_i;
    // A line end only counts for a line whose beats were counted in this frame.
    assign w_le       = r_dv_q & ~dv_i & r_inline & (r_state != S_IDLE);
    assign w_ovf_beat = r_inline && (col_o == COL_MAX);
    assign w_pcol     = !r_inline ? '0 : (w_ovf_beat ? col_o : col_o + CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dv_q      <= 1'b0;
            r_vs_q      <= 1'b0;
            r_inline    <= 1'b0;
            line_end_o  <= 1'b0;
            col_o       <= '0;
            row_o       <= '0;
            win_valid_o <= 1'b0;
            run_o       <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            r_dv_q      <= dv_i;
            r_vs_q      <= vs_i;
            line_end_o  <= w_fs | w_le;
            win_valid_o <= 1'b0;
            if (w_fs) begin
                row_o       <= '0;
                col_o       <= '0;
                ovf_o       <= 1'b0;
                r_inline    <= dv_i;
                r_state     <= (BUF_DEPTH == 1) ? S_RUN : S_FILL;
                run_o       <= (BUF_DEPTH == 1);
                win_valid_o <= (BUF_DEPTH == 1) && dv_i;
            end else if (r_state != S_IDLE) begin
                if (w_le) begin
                    col_o    <= '0;
                    r_inline <= 1'b0;
                    if (row_o != ROW_MAX)
                        row_o <= row_o + RW'(1);
                    if (r_state == S_FILL && row_o == FILL_LAST) begin
                        r_state <= S_RUN;
                        run_o   <= 1'b1;
                    end
                end else if (dv_i) begin
                    col_o       <= w_pcol;
                    r_inline    <= 1'b1;
                    if (w_ovf_beat)
                        ovf_o <= 1'b1;
                    win_valid_o <= (r_state == S_RUN) && !w_ovf_beat && (w_pcol >= WIN_COL);
                end
            end
        end
    end

`ifdef LINEBUF_CTRL_STATS_EN
    // col_o holds the saturated column of the last pixel when the line end is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_o  <= '0;
            height_o <= '0;
        end else if (w_fs) begin
            height_o <= row_o;
        end else if (w_le) begin
            width_o  <= col_o + CW'(1);
        end
    end
`else
    assign width_o  = '0;
    assign height_o = '0;
`endif

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Self-checking bench for linebuf_ctrl: directed scenarios plus random dv/vs traffic,
// every cycle compared against a frame/line/pixel-count model.
module tb_linebuf_ctrl;
    localparam int SW = 16;
    localparam int LE = 64;
    localparam int ML = 8;
    localparam int BD = 3;
    localparam int CW = 6;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst, dv_i, vs_i;
    logic          line_end_o, win_valid_o, run_o, ovf_o;
    logic [CW-1:0] col_o, width_o;
    logic [RW-1:0] row_o, height_o;

    int checks = 0, failures = 0;
    bit chk_en = 0;
    int cnt_le = 0, cnt_win = 0, mcnt_win = 0;

    // model: frame active flag, completed lines and beats of the current line
    bit m_active, m_dvq, m_vsq;
    int m_lines, m_pix;
    int e_le, e_col, e_row, e_win, e_run, e_ovf, e_w, e_h;

    linebuf_ctrl #(.SCREENWIDTH(SW), .LINE_END(LE), .MAX_LINES(ML), .BUF_DEPTH(BD)) dut (
        .clk(clk), .rst(rst), .dv_i(dv_i), .vs_i(vs_i),
        .line_end_o(line_end_o), .col_o(col_o), .row_o(row_o), .win_valid_o(win_valid_o),
        .run_o(run_o), .ovf_o(ovf_o), .width_o(width_o), .height_o(height_o)
    );

    always #5 clk = ~clk;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_dvq = 0; m_vsq = 0; m_lines = 0; m_pix = 0;
        e_le = 0; e_col = 0; e_row = 0; e_win = 0; e_run = 0; e_ovf = 0; e_w = 0; e_h = 0;
    endtask

    task automatic model_step(input logic dv, input logic vs);
        bit fs, le;
        fs = vs && !m_vsq;
        le = m_dvq && !dv && m_active && (m_pix > 0);
        e_le  = (fs || le) ? 1 : 0;
        e_win = 0;
        if (fs) begin
            e_h = imin(m_lines, ML - 1);
            m_active = 1; m_lines = 0; m_pix = dv ? 1 : 0;
            e_col = 0; e_row = 0; e_ovf = 0;
            e_win = (dv && BD == 1) ? 1 : 0;
        end else if (m_active) begin
            if (le) begin
                e_w = imin(m_pix, SW);
                m_lines++; m_pix = 0;
                e_col = 0; e_row = imin(m_lines, ML - 1);
            end else if (dv) begin
                m_pix++;
                e_col = imin(m_pix - 1, SW - 1);
                if (m_pix > SW) e_ovf = 1;
                e_win = (m_lines >= BD - 1 && m_pix <= SW && e_col >= BD - 1) ? 1 : 0;
            end
        end
        e_run = (m_active && m_lines >= BD - 1) ? 1 : 0;
        mcnt_win += e_win;
        m_dvq = dv; m_vsq = vs;
    endtask

    task automatic cyc(input logic dv, input logic vs);
        dv_i = dv; vs_i = vs;
        @(posedge clk); #1;
        model_step(dv, vs);
    endtask

    task automatic line(input int n, input logic vs);
        repeat (n) cyc(1'b1, vs);
        cyc(1'b0, vs);
        cyc(1'b0, vs);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_line_end"}, line_end_o, 0);
        chk({tag, "_col"}, col_o, 0);
        chk({tag, "_row"}, row_o, 0);
        chk({tag, "_win"}, win_valid_o, 0);
        chk({tag, "_run"}, run_o, 0);
        chk({tag, "_ovf"}, ovf_o, 0);
        chk({tag, "_width"}, width_o, 0);
        chk({tag, "_height"}, height_o, 0);
    endtask

    // asserted away from the clock edge so the clear must be asynchronous
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("line_end_o", line_end_o, e_le);
                chk("col_o", col_o, e_col);
                chk("row_o", row_o, e_row);
                chk("win_valid_o", win_valid_o, e_win);
                chk("run_o", run_o, e_run);
                chk("ovf_o", ovf_o, e_ovf);
`ifdef LINEBUF_CTRL_STATS_EN
                chk("width_o", width_o, e_w);
                chk("height_o", height_o, e_h);
`else
                chk("width_o", width_o, 0);
                chk("height_o", height_o, 0);
`endif
                cnt_le  += int'(line_end_o);
                cnt_win += int'(win_valid_o);
            end
        end
    end

    initial begin
        logic dvr, vsr;
        rst = 1'b1; dv_i = 1'b0; vs_i = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk_zero("reset");
        rst = 1'b0;
        chk_en = 1;

        // beats while IDLE are ignored
        cnt_le = 0; cnt_win = 0;
        repeat (5) cyc(1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("idle_le_cnt", cnt_le, 0);
        chk("idle_win_cnt", cnt_win, 0);
        chk("idle_col", col_o, 0);
        chk("idle_row", row_o, 0);

        // frame start then 3 lines x 8 px
        cnt_le = 0; cnt_win = 0; mcnt_win = 0;
        cyc(1'b0, 1'b1);
        repeat (3) line(8, 1'b1);
        chk("fill_le_cnt", cnt_le, 4);
        chk("fill_win_cnt", cnt_win, 6);
        chk("fill_model_win", mcnt_win, 6);
        chk("fill_run", run_o, 1);
        chk("fill_row", row_o, 3);

        // 20 px line: saturate at 15, overflow from beat 17
        repeat (16) cyc(1'b1, 1'b1);
        chk("sat_col16", col_o, 15);
        chk("sat_ovf16", ovf_o, 0);
        cyc(1'b1, 1'b1);
        chk("sat_col17", col_o, 15);
        chk("sat_ovf17", ovf_o, 1);
        repeat (3) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        chk("restart_col", col_o, 0);
        repeat (3) cyc(1'b1, 1'b1);
        chk("restart_col3", col_o, 3);
        chk("ovf_sticky", ovf_o, 1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("vs_ovf_clr", ovf_o, 0);
        chk("vs_le_pulse", line_end_o, 1);

        // frame start coinciding with dv fall in RUN
        line(5, 1'b0); line(5, 1'b0);
        chk("pre_sim_run", run_o, 1);
        repeat (18) cyc(1'b1, 1'b0);
        cnt_le = 0;
        cyc(1'b0, 1'b1); cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
        chk("sim_le_cnt", cnt_le, 1);
        chk("sim_row", row_o, 0);
        chk("sim_run", run_o, 0);
        chk("sim_ovf", ovf_o, 0);

        // reset mid-line in RUN; resume only after vs rise
        line(4, 1'b1); line(4, 1'b1);
        repeat (3) cyc(1'b1, 1'b1);
        chk("pre_rst_run", run_o, 1);
        do_reset();
        cnt_le = 0; cnt_win = 0;
        repeat (3) line(5, 1'b0);
        chk("post_rst_run", run_o, 0);
        chk("post_rst_win", cnt_win, 0);
        chk("post_rst_le", cnt_le, 0);
        cyc(1'b0, 1'b1);
        line(5, 1'b1); line(5, 1'b1);
        chk("resume_run", run_o, 1);

        // stats: 5 lines x 10 px then new frame
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        repeat (5) line(10, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
`ifdef LINEBUF_CTRL_STATS_EN
        chk("stats_width", width_o, 10);
        chk("stats_height", height_o, 5);
`else
        chk("stats_width", width_o, 0);
        chk("stats_height", height_o, 0);
`endif

        // random traffic
        vsr = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) vsr = ~vsr;
            dvr = ($urandom_range(0, 7) != 0);
            if (i == 1500) do_reset();
            cyc(dvr, vsr);
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
